id_ex_fwd_stage: RTL and testbench
==================================

ID_EX_FWD_STAGE -- requirements
Module: id_ex_fwd_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, operand data width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  discard the instruction entering EX this cycle.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  source and destination register numbers.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data.
- id_reg_we  in  1  instruction writes rd.
- id_mem_rd  in  1  instruction is a load.
- ex_ready  in  1  EX consumes the current EX instruction.
- ex_valid  out  1  EX holds a valid instruction.
- ex_rs1_data, ex_rs2_data  out  DATA_WIDTH  registered operands.
- ex_rd_addr  out  REG_AW  registered destination.
- ex_reg_we, ex_mem_rd  out  1  registered controls.
- mem_rd_addr  in  REG_AW, mem_reg_we  in  1  instruction in the EX/MEM stage.
- wb_rd_addr  in  REG_AW, wb_reg_we  in  1  instruction in the MEM/WB stage.
- fwd_sel_a, fwd_sel_b  out  2  select codes for the EX 3-input operand muxes.
- stall_cnt  out  16  count of inserted load-use bubbles.

Function
REQ-004 Advance condition adv = !ex_valid | ex_ready.
REQ-005 Hazard haz = ex_valid & ex_mem_rd & ex_reg_we & (ex_rd_addr != 0) & id_valid & (id_rs1_addr == ex_rd_addr | id_rs2_addr == ex_rd_addr).
REQ-006 id_ready SHALL equal adv & !haz (combinational).
REQ-007 When adv is 0, all EX registers SHALL hold their values.
REQ-008 When adv is 1 and flush is 1, ex_valid SHALL become 0; flush overrides haz and id_valid.
REQ-009 When adv is 1, flush is 0 and haz is 1, ex_valid SHALL become 0 for exactly one cycle (bubble) and stall_cnt SHALL increment.
REQ-010 When adv is 1, flush is 0 and haz is 0, ex_valid SHALL load id_valid and all ex_* payload registers SHALL load the id_* values, including registered rs1/rs2 addresses.
REQ-011 Payload registers SHALL NOT update while ex_valid would load 0, except ex_reg_we and ex_mem_rd, which SHALL clear so a bubble never writes or triggers a hazard.
REQ-012 Load-to-EX latency SHALL be 1 cycle; the bubble delays the dependent instruction by exactly 1 cycle.
REQ-013 fwd_sel_a SHALL be combinational from the registered rs1 address: 2'b01 if mem_reg_we & mem_rd_addr == rs1 & rs1 != 0; else 2'b10 if wb_reg_we & wb_rd_addr == rs1 & rs1 != 0; else 2'b00. fwd_sel_b SHALL be computed the same way from rs2.
REQ-014 When the MEM and WB stages both match, 2'b01 (newer result) SHALL win.
REQ-015 Register x0 SHALL never select forwarding; code 2'b11 SHALL never be driven.
REQ-016 fwd_sel_a and fwd_sel_b SHALL be 2'b00 whenever ex_valid is 0.
REQ-017 stall_cnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-018 rst_n low SHALL immediately clear ex_valid, ex_reg_we, ex_mem_rd, ex_rd_addr, the registered rs addresses, ex_rs1_data, ex_rs2_data and stall_cnt to 0.
REQ-019 During reset, fwd_sel_a and fwd_sel_b SHALL be 2'b00 and id_ready SHALL be 1.
REQ-020 Reset asserted mid-stall SHALL drop the pending bubble; the first instruction after release SHALL be accepted normally.

Verification
REQ-021 Load x5 then add x6,x5,x1 back-to-back, ex_ready=1 -> id_ready=0 for 1 cycle, one bubble (ex_valid=0), stall_cnt=1; the add then enters EX with fwd_sel_a=2'b10 while the load is in WB.
REQ-022 EX holds add x3,x1,x2 with mem_rd_addr=1 and mem_reg_we=1; wb_rd_addr=2 and wb_reg_we=1 -> fwd_sel_a=01, fwd_sel_b=10. With mem and wb both =1 -> fwd_sel_a=01.
REQ-023 Instruction with rs1=0, mem_rd_addr=0 and mem_reg_we=1 -> fwd_sel_a=00.
REQ-024 ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0 and ex_* stable; on release the next instruction loads in 1 cycle.
REQ-025 flush=1 in the same cycle as haz=1 -> ex_valid=0 and stall_cnt unchanged.
REQ-026 stall_cnt preset via 65535 hazards, then one more hazard -> stall_cnt stays 16'hFFFF. rst_n pulsed low asynchronously mid-cycle -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// forwarding select generation for the EX operand muxes and a saturating
// bubble counter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module id_ex_fwd_stage #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_AW-1:0]     id_rs1_addr,
  input  logic [REG_AW-1:0]     id_rs2_addr,
  input  logic [REG_AW-1:0]     id_rd_addr,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic                  id_reg_we,
  input  logic                  id_mem_rd,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [REG_AW-1:0]     ex_rd_addr,
  output logic                  ex_reg_we,
  output logic                  ex_mem_rd,
  input  logic [REG_AW-1:0]     mem_rd_addr,
  input  logic                  mem_reg_we,
  input  logic [REG_AW-1:0]     wb_rd_addr,
  input  logic                  wb_reg_we,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [15:0]           stall_cnt
);

  logic                  valid_q, valid_d;
  logic                  reg_we_q, reg_we_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [REG_AW-1:0]     rd_addr_q, rd_addr_d;
  logic [REG_AW-1:0]     rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0]     rs2_addr_q, rs2_addr_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  logic adv;
  logic haz;

  // The EX slot can take a new instruction when empty or being consumed;
  // a load in EX feeding a source of the ID instruction forces one bubble.
  always_comb begin
    adv = !valid_q || ex_ready;
    haz = valid_q && mem_rd_q && reg_we_q && (rd_addr_q != '0) && id_valid &&
          ((id_rs1_addr == rd_addr_q) || (id_rs2_addr == rd_addr_q));
    id_ready = adv && !haz;
  end

  // Next state of the EX registers: hold, flush, bubble or load from ID.
  // Payload is only overwritten by a real instruction; the write/load
  // controls are cleared whenever the slot empties so a bubble is inert.
  always_comb begin
    valid_d     = valid_q;
    reg_we_d    = reg_we_q;
    mem_rd_d    = mem_rd_q;
    rd_addr_d   = rd_addr_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    stall_cnt_d = stall_cnt_q;
    if (adv) begin
      if (flush || haz || !id_valid) begin
        valid_d  = 1'b0;
        reg_we_d = 1'b0;
        mem_rd_d = 1'b0;
        if (!flush && haz && (stall_cnt_q != 16'hFFFF)) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end else begin
        valid_d    = 1'b1;
        reg_we_d   = id_reg_we;
        mem_rd_d   = id_mem_rd;
        rd_addr_d  = id_rd_addr;
        rs1_addr_d = id_rs1_addr;
        rs2_addr_d = id_rs2_addr;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
      end
    end
  end

  // EX stage state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      rd_addr_q   <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_we_q    <= reg_we_d;
      mem_rd_q    <= mem_rd_d;
      rd_addr_q   <= rd_addr_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Forwarding selects: MEM (newest) beats WB, x0 never forwards, and an
  // empty EX slot always selects the register-file operand.
  always_comb begin
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
    if (valid_q) begin
      if (mem_reg_we && (mem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) begin
        fwd_sel_a = 2'b01;
      end else if (wb_reg_we && (wb_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) begin
        fwd_sel_a = 2'b10;
      end
      if (mem_reg_we && (mem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) begin
        fwd_sel_b = 2'b01;
      end else if (wb_reg_we && (wb_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) begin
        fwd_sel_b = 2'b10;
      end
    end
  end

  assign ex_valid    = valid_q;
  assign ex_reg_we   = reg_we_q;
  assign ex_mem_rd   = mem_rd_q;
  assign ex_rd_addr  = rd_addr_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed testbench for id_ex_fwd_stage: load-use bubble, forwarding
// selects, back-pressure, flush priority, counter saturation and reset.
module tb_id_ex_fwd_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [DW-1:0] id_rs1_data, id_rs2_data;
  logic          id_reg_we, id_mem_rd;
  logic          ex_ready;
  logic          ex_valid;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_reg_we, ex_mem_rd;
  logic [AW-1:0] mem_rd_addr, wb_rd_addr;
  logic          mem_reg_we, wb_reg_we;
  logic [1:0]    fwd_sel_a, fwd_sel_b;
  logic [15:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage #(.DATA_WIDTH(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
    .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we),
    .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we, input logic mrd,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    id_valid    = 1'b1;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rd_addr  = rd;
    id_reg_we   = we;
    id_mem_rd   = mrd;
    id_rs1_data = d1;
    id_rs2_data = d2;
  endtask

  task automatic clear_pipe();
    mem_rd_addr = '0;
    mem_reg_we  = 1'b0;
    wb_rd_addr  = '0;
    wb_reg_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    id_valid = 1'b0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_data = '0; id_rs2_data = '0;
    id_reg_we = 1'b0; id_mem_rd = 1'b0;
    clear_pipe();

    // Reset state
    #2;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    check("rst_fwd_a", 32'(fwd_sel_a), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Load x5 followed by dependent add x6,x5,x1
    present(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'd100, 32'd0);
    tick();
    check("ld_ex_valid", 32'(ex_valid), 32'd1);
    check("ld_ex_rd", 32'(ex_rd_addr), 32'd5);
    check("ld_ex_mem_rd", 32'(ex_mem_rd), 32'd1);
    check("ld_ex_rs1_data", ex_rs1_data, 32'd100);
    present(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 32'd7, 32'd8);
    #1;
    check("lu_id_ready", 32'(id_ready), 32'd0);
    tick();
    mem_rd_addr = 5'd5; mem_reg_we = 1'b1;
    #1;
    check("bub_ex_valid", 32'(ex_valid), 32'd0);
    check("bub_stall_cnt", 32'(stall_cnt), 32'd1);
    check("bub_ex_reg_we", 32'(ex_reg_we), 32'd0);
    check("bub_ex_mem_rd", 32'(ex_mem_rd), 32'd0);
    check("bub_ex_rd_hold", 32'(ex_rd_addr), 32'd5);
    check("bub_id_ready", 32'(id_ready), 32'd1);
    tick();
    clear_pipe();
    wb_rd_addr = 5'd5; wb_reg_we = 1'b1;
    #1;
    check("add_ex_valid", 32'(ex_valid), 32'd1);
    check("add_ex_rd", 32'(ex_rd_addr), 32'd6);
    check("add_ex_rs1_data", ex_rs1_data, 32'd7);
    check("add_ex_rs2_data", ex_rs2_data, 32'd8);
    check("add_fwd_a_wb", 32'(fwd_sel_a), 32'd2);
    check("add_fwd_b", 32'(fwd_sel_b), 32'd0);
    check("add_stall_cnt", 32'(stall_cnt), 32'd1);

    // add x3,x1,x2 with forwarding from MEM and WB
    clear_pipe();
    present(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd1, 32'd2);
    tick();
    mem_rd_addr = 5'd1; mem_reg_we = 1'b1;
    wb_rd_addr = 5'd2; wb_reg_we = 1'b1;
    #1;
    check("fw_a_mem", 32'(fwd_sel_a), 32'd1);
    check("fw_b_wb", 32'(fwd_sel_b), 32'd2);
    wb_rd_addr = 5'd1;
    #1;
    check("fw_a_both", 32'(fwd_sel_a), 32'd1);
    check("fw_b_none", 32'(fwd_sel_b), 32'd0);
    mem_reg_we = 1'b0;
    #1;
    check("fw_a_wb_only", 32'(fwd_sel_a), 32'd2);
    // Empty EX slot never forwards, even though its held rs1 still matches
    mem_reg_we = 1'b1;
    id_valid = 1'b0;
    tick();
    check("empty_ex_valid", 32'(ex_valid), 32'd0);
    check("empty_fwd_a", 32'(fwd_sel_a), 32'd0);

    // x0 never forwards
    present(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'd0, 32'd0);
    tick();
    mem_rd_addr = 5'd0; mem_reg_we = 1'b1;
    wb_rd_addr = 5'd0; wb_reg_we = 1'b1;
    #1;
    check("x0_fwd_a", 32'(fwd_sel_a), 32'd0);
    check("x0_fwd_b", 32'(fwd_sel_b), 32'd0);
    clear_pipe();

    // Back-pressure for 3 cycles
    present(5'd9, 5'd10, 5'd7, 1'b1, 1'b0, 32'd11, 32'd12);
    tick();
    ex_ready = 1'b0;
    present(5'd11, 5'd12, 5'd8, 1'b1, 1'b0, 32'd22, 32'd23);
    #1;
    check("bp_id_ready", 32'(id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_rd_%0d", i), 32'(ex_rd_addr), 32'd7);
      check($sformatf("bp_hold_d1_%0d", i), ex_rs1_data, 32'd11);
      check($sformatf("bp_hold_v_%0d", i), 32'(ex_valid), 32'd1);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_rel_id_ready", 32'(id_ready), 32'd1);
    tick();
    check("bp_next_rd", 32'(ex_rd_addr), 32'd8);
    check("bp_next_d1", ex_rs1_data, 32'd22);

    // Flush in the same cycle as a hazard
    present(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'd50, 32'd0);
    tick();
    present(5'd0, 5'd5, 5'd6, 1'b1, 1'b0, 32'd1, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    check("fl_ex_valid", 32'(ex_valid), 32'd0);
    check("fl_stall_cnt", 32'(stall_cnt), 32'd1);

    // Saturation: preset the counter near the top, then three more bubbles
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) begin
      present(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'd0, 32'd0);
      tick();
      present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd0, 32'd0);
      tick();
      check($sformatf("sat_cnt_%0d", i), 32'(stall_cnt), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end

    // Asynchronous reset mid-stall
    present(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 32'd77, 32'd78);
    tick();
    present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 32'd1, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ex_valid", 32'(ex_valid), 32'd0);
    check("ar_ex_rd", 32'(ex_rd_addr), 32'd0);
    check("ar_ex_d1", ex_rs1_data, 32'd0);
    check("ar_ex_d2", ex_rs2_data, 32'd0);
    check("ar_ex_we", 32'(ex_reg_we), 32'd0);
    check("ar_ex_mem_rd", 32'(ex_mem_rd), 32'd0);
    check("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    check("ar_fwd_a", 32'(fwd_sel_a), 32'd0);
    check("ar_id_ready", 32'(id_ready), 32'd1);
    tick();
    #2;
    rst_n = 1'b1;
    present(5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 32'd33, 32'd0);
    tick();
    check("post_rst_valid", 32'(ex_valid), 32'd1);
    check("post_rst_rd", 32'(ex_rd_addr), 32'd9);
    check("post_rst_cnt", 32'(stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
